// File: rtl/rv_test_sequencer.sv
// rv_test_sequencer: runs a set of enabled test slots back to back on one core.
// Each slot resets the core with its own boot PC, waits for a result strobe,
// and records pass / mismatch / timeout.
module rv_test_sequencer #(
    parameter int NUM_TESTS    = 6,
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 256,
    localparam int IDX_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_TESTS-1:0]        test_en,
    input  logic [NUM_TESTS*PC_W-1:0]   entry_pc,
    input  logic [NUM_TESTS*DATA_W-1:0] exp_data,
    input  logic                        res_valid,
    input  logic [DATA_W-1:0]           res_data,
    output logic                        core_rst,
    output logic [PC_W-1:0]             core_pc,
    output logic                        busy,
    output logic [IDX_W-1:0]            test_idx,
    output logic [NUM_TESTS-1:0]        pass_mask,
    output logic [NUM_TESTS-1:0]        timeout_mask,
    output logic [IDX_W:0]              fail_cnt,
    output logic                        done
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state;
    logic [RC_W-1:0]    rst_cnt;
    logic [TO_W-1:0]    run_cnt;
    logic [DATA_W-1:0]  res_q;

    logic [PC_W-1:0]    pc_slot  [NUM_TESTS];
    logic [DATA_W-1:0]  exp_slot [NUM_TESTS];

    logic               first_found;
    logic [IDX_W-1:0]   first_idx;
    logic               next_found;
    logic [IDX_W-1:0]   next_idx;

    // Unpack the per-slot boot PCs and expected values
    always_comb begin
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
            pc_slot[i]  = entry_pc[i*PC_W +: PC_W];
            exp_slot[i] = exp_data[i*DATA_W +: DATA_W];
        end
    end

    // Lowest enabled slot overall, and lowest enabled slot above test_idx
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        // Scan downward so the last hit is the lowest index
        for (int unsigned i = NUM_TESTS; i > 0; i--) begin
            if (test_en[i-1]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i-1);
                if (IDX_W'(i-1) > test_idx) begin
                    next_found = 1'b1;
                    next_idx   = IDX_W'(i-1);
                end
            end
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            core_rst     <= 1'b1;
            core_pc      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            test_idx     <= '0;
            pass_mask    <= '0;
            timeout_mask <= '0;
            fail_cnt     <= '0;
            rst_cnt      <= '0;
            run_cnt      <= '0;
            res_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    core_rst <= 1'b1;
                    if (start) begin
                        pass_mask    <= '0;
                        timeout_mask <= '0;
                        fail_cnt     <= '0;
                        test_idx     <= first_idx;
                        if (first_found) begin
                            core_pc <= pc_slot[first_idx];
                            rst_cnt <= '0;
                            busy    <= 1'b1;
                            state   <= S_RESET;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RC_W'(RESET_CYCLES-1)) begin
                        core_rst <= 1'b0;
                        run_cnt  <= '0;
                        state    <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // A result in the final counted cycle wins over the timeout
                    if (res_valid) begin
                        res_q    <= res_data;
                        core_rst <= 1'b1;
                        state    <= S_CHECK;
                    end else if (run_cnt == TO_W'(TIMEOUT-1)) begin
                        timeout_mask[test_idx] <= 1'b1;
                        fail_cnt <= fail_cnt + 1'b1;
                        core_rst <= 1'b1;
                        state    <= S_NEXT;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (res_q == exp_slot[test_idx]) begin
                        pass_mask[test_idx] <= 1'b1;
                    end else begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (next_found) begin
                        test_idx <= next_idx;
                        core_pc  <= pc_slot[next_idx];
                        rst_cnt  <= '0;
                        state    <= S_RESET;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_test_sequencer.sv
// Scoreboard bench for rv_test_sequencer: a model core answers each RUN phase,
// and monitors check boot PC/slot/timing at RUN entry and final status at done.
module tb_rv_test_sequencer;

    localparam int NT  = 4;
    localparam int RC  = 4;
    localparam int TO  = 16;
    localparam int W   = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [NT-1:0]     test_en;
    logic [NT*W-1:0]   entry_pc;
    logic [NT*W-1:0]   exp_data;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic              core_rst;
    logic [W-1:0]      core_pc;
    logic              busy;
    logic [1:0]        test_idx;
    logic [NT-1:0]     pass_mask;
    logic [NT-1:0]     timeout_mask;
    logic [2:0]        fail_cnt;
    logic              done;

    rv_test_sequencer #(
        .NUM_TESTS   (NT),
        .PC_W        (W),
        .DATA_W      (W),
        .RESET_CYCLES(RC),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .test_en     (test_en),
        .entry_pc    (entry_pc),
        .exp_data    (exp_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .core_rst    (core_rst),
        .core_pc     (core_pc),
        .busy        (busy),
        .test_idx    (test_idx),
        .pass_mask   (pass_mask),
        .timeout_mask(timeout_mask),
        .fail_cnt    (fail_cnt),
        .done        (done)
    );

    typedef struct {
        int unsigned idx;
        logic [W-1:0] pc;
        int unsigned t;
    } boot_t;

    typedef struct {
        logic [NT-1:0] pass;
        logic [NT-1:0] tmo;
        int unsigned   fcnt;
        int unsigned   idx;
        int unsigned   t;
    } done_t;

    boot_t boot_q[$];
    done_t done_q[$];

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    int          k_cfg   [NT];
    logic [W-1:0] val_cfg [NT];
    logic [W-1:0] pc_cfg  [NT];
    logic        noise_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] pc, input logic [W-1:0] ev,
                            input int k, input logic [W-1:0] val);
        pc_cfg[i]  = pc;
        val_cfg[i] = val;
        k_cfg[i]   = k;
        entry_pc[i*W +: W] = pc;
        exp_data[i*W +: W] = ev;
    endtask

    // Model core: answers on RUN cycle k_cfg[slot] (never when k < 0)
    initial begin
        int unsigned rc;
        logic prev;
        res_valid = 1'b0;
        res_data  = '0;
        rc   = 0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (core_rst === 1'b0) begin
                rc = prev ? 0 : rc + 1;
                if (k_cfg[test_idx] >= 0 && int'(rc) == k_cfg[test_idx]) begin
                    res_valid = 1'b1;
                    res_data  = val_cfg[test_idx];
                end else begin
                    res_valid = 1'b0;
                    res_data  = '0;
                end
            end else begin
                res_valid = noise_en;
                res_data  = 32'hDEAD_BEEF;
            end
            prev = (core_rst !== 1'b0);
        end
    end

    // Monitor: RUN entry and done pulse compared against the scoreboard
    initial begin
        logic prev;
        boot_t b;
        done_t d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && core_rst === 1'b0) begin
                if (boot_q.size() == 0) begin
                    checks = checks + 1;
                    failures = failures + 1;
                    $display("FAIL boot_unexpected: got slot %0d expected no run", test_idx);
                end else begin
                    b = boot_q.pop_front();
                    check("boot_idx", 64'(test_idx), 64'(b.idx));
                    check("boot_pc", 64'(core_pc), 64'(b.pc));
                    check("boot_cycle", 64'(cyc), 64'(b.t));
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks = checks + 1;
                    failures = failures + 1;
                    $display("FAIL done_unexpected: got done=1 expected none at cycle %0d", cyc);
                end else begin
                    d = done_q.pop_front();
                    check("done_pass_mask", 64'(pass_mask), 64'(d.pass));
                    check("done_timeout_mask", 64'(timeout_mask), 64'(d.tmo));
                    check("done_fail_cnt", 64'(fail_cnt), 64'(d.fcnt));
                    check("done_test_idx", 64'(test_idx), 64'(d.idx));
                    check("done_cycle", 64'(cyc), 64'(d.t));
                    check("done_busy", 64'(busy), 64'(0));
                end
            end
            prev = (core_rst !== 1'b0);
        end
    end

    // Timing model: pushes expected boots, returns the cycle of the done pulse
    task automatic model(input logic [NT-1:0] en, input int unsigned t0, output int unsigned tdone);
        int unsigned t;
        boot_t b;
        t = t0 + 1;
        for (int i = 0; i < NT; i++) begin
            if (en[i]) begin
                b.idx = i;
                b.pc  = pc_cfg[i];
                b.t   = t + RC;
                boot_q.push_back(b);
                if (k_cfg[i] >= 0 && k_cfg[i] < TO)
                    t = t + RC + int'(k_cfg[i]) + 1 + 2;
                else
                    t = t + RC + TO + 1;
            end
        end
        tdone = t;
    endtask

    task automatic run_seq(input logic [NT-1:0] en, input logic [NT-1:0] xp, input logic [NT-1:0] xt,
                           input int unsigned xf, input int unsigned xidx, input int unsigned extra);
        done_t d;
        int unsigned tdone;
        int unsigned n;
        logic got;
        @(negedge clk);
        test_en = en;
        start   = 1'b1;
        model(en, cyc, tdone);
        d.pass = xp;
        d.tmo  = xt;
        d.fcnt = xf;
        d.idx  = xidx;
        d.t    = tdone;
        done_q.push_back(d);
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
            start = (extra != 0 && n + 1 == extra);
            n = n + 1;
        end
        start = 1'b0;
        if (!got) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL done_wait: got no done pulse expected one within 400 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        rst      = 1'b1;
        start    = 1'b0;
        test_en  = '0;
        entry_pc = '0;
        exp_data = '0;
        for (int i = 0; i < NT; i++) set_slot(i, 32'h0, 32'h0, -1, 32'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_core_rst", 64'(core_rst), 64'(1));
        check("rst_core_pc", 64'(core_pc), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_test_idx", 64'(test_idx), 64'(0));
        check("rst_pass_mask", 64'(pass_mask), 64'(0));
        check("rst_timeout_mask", 64'(timeout_mask), 64'(0));
        check("rst_fail_cnt", 64'(fail_cnt), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1. Basic pass: done at start+11
        set_slot(0, 32'h0, 32'h0000_000A, 3, 32'h0000_000A);
        run_seq(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);

        // 2. Mismatch plus skip, with stray strobes outside RUN
        noise_en = 1'b1;
        set_slot(1, 32'h0000_0100, 32'h0000_0005, 2, 32'h0000_0005);
        set_slot(3, 32'h0000_0300, 32'hFFFF_FFFF, 5, 32'h7FFF_FFFF);
        run_seq(4'b1010, 4'b0010, 4'b0000, 1, 3, 0);
        noise_en = 1'b0;

        // 3. Timeout
        set_slot(0, 32'h0000_0040, 32'h0000_000A, -1, 32'h0);
        run_seq(4'b0001, 4'b0000, 4'b0001, 1, 0, 0);

        // 4. Result in the timeout cycle
        set_slot(0, 32'h0000_0040, 32'h0000_000A, 15, 32'h0000_000A);
        run_seq(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);

        // 5a. Empty mask: done one cycle after start
        run_seq(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        check("empty_core_rst", 64'(core_rst), 64'(1));

        // 5b. Second start during slot1 reset phase is ignored
        set_slot(0, 32'h0000_0010, 32'h0000_0011, 1, 32'h0000_0011);
        set_slot(1, 32'h0000_0100, 32'h0000_0005, 2, 32'h0000_0005);
        run_seq(4'b0011, 4'b0011, 4'b0000, 0, 1, 8);

        // 7. All slots: pass at RUN cycle 0, timeout, mismatch, pass
        set_slot(0, 32'h0000_1000, 32'h1234_5678, 0, 32'h1234_5678);
        set_slot(1, 32'h0000_2000, 32'h0000_0001, -1, 32'h0);
        set_slot(2, 32'h0000_3000, 32'h0000_0002, 4, 32'h0000_0003);
        set_slot(3, 32'h0000_4000, 32'hCAFE_F00D, 7, 32'hCAFE_F00D);
        run_seq(4'b1111, 4'b1001, 4'b0010, 2, 3, 0);

        // 6. Reset during RUN of slot2 after slot0 passed
        set_slot(0, 32'h0000_0010, 32'h0000_0011, 1, 32'h0000_0011);
        set_slot(2, 32'h0000_3000, 32'h0000_0002, -1, 32'h0);
        @(negedge clk);
        test_en = 4'b0101;
        start   = 1'b1;
        begin
            int unsigned tdummy;
            model(4'b0101, cyc, tdummy);
        end
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(core_rst === 1'b0 && test_idx == 2'd2) && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 200) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL slot2_run_wait: got no RUN of slot 2 expected within 200 cycles");
        end
        repeat (3) @(negedge clk);
        check("pre_rst_pass_mask", 64'(pass_mask), 64'(4'b0001));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_core_rst", 64'(core_rst), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_pass_mask", 64'(pass_mask), 64'(0));
        check("midrst_timeout_mask", 64'(timeout_mask), 64'(0));
        check("midrst_fail_cnt", 64'(fail_cnt), 64'(0));
        check("midrst_test_idx", 64'(test_idx), 64'(0));
        check("midrst_core_pc", 64'(core_pc), 64'(0));
        repeat (30) @(negedge clk);
        check("midrst_idle_core_rst", 64'(core_rst), 64'(1));

        // Sequencer still usable after the abort
        set_slot(0, 32'h0000_0000, 32'h0000_000A, 3, 32'h0000_000A);
        run_seq(4'b0001, 4'b0001, 4'b0000, 0, 0, 0);

        check("boot_queue_drained", 64'(boot_q.size()), 64'(0));
        check("done_queue_drained", 64'(done_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_test_sequencer.md
Name: rv_test_sequencer

Overview:
- Synthesizable self-check sequencer for RV32i arithmetic/logic regression.
- Runs up to NUM_TESTS programs back to back on one core: asserts core reset, loads a per-test boot PC, waits for the core to report a result, and compares it against an expected value.
- Sits between the bench/top and the core's reset/boot-PC inputs.
- Returns pass, fail and timeout status per test without stopping the bench.

Parameters:
- NUM_TESTS, 6: number of test slots; minimum 1.
- PC_W, 32: boot PC width.
- DATA_W, 32: result and expected-value width.
- RESET_CYCLES, 4: cycles core_rst is held per test; minimum 1.
- TIMEOUT, 256: maximum RUN cycles before a test is declared timed out; minimum 2.
- IDX_W (localparam), $clog2(NUM_TESTS) with a minimum of 1: index width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- test_en  in  NUM_TESTS  enable mask; disabled slots are skipped.
- entry_pc  in  NUM_TESTS*PC_W  boot PC per slot; slot i is bits [i*PC_W +: PC_W].
- exp_data  in  NUM_TESTS*DATA_W  expected result per slot, packed the same way.
- res_valid  in  1  core result strobe.
- res_data  in  DATA_W  core result, qualified by res_valid.
- core_rst  out  1  active-high reset to the core.
- core_pc  out  PC_W  boot PC to the core.
- busy  out  1  sequence in progress.
- test_idx  out  IDX_W  slot currently running or last run.
- pass_mask  out  NUM_TESTS  bit i = slot i passed.
- timeout_mask  out  NUM_TESTS  bit i = slot i timed out.
- fail_cnt  out  IDX_W+1  mismatches plus timeouts.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset values: state IDLE, core_rst=1, core_pc=0, busy=0, done=0, test_idx=0, pass_mask=0, timeout_mask=0, fail_cnt=0, internal counters 0.
- All outputs are registered.
- States: IDLE, RESET, RUN, CHECK, NEXT, DONE.
- IDLE:
  - core_rst=1.
  - On start=1: clear pass_mask, timeout_mask and fail_cnt; test_idx = lowest set bit of test_en.
  - If test_en==0, go to DONE; otherwise go to RESET.
  - busy=1 from the cycle after start.
- RESET:
  - core_rst=1 and core_pc=entry_pc[test_idx] for exactly RESET_CYCLES cycles, then go to RUN.
- RUN:
  - core_rst=0 and core_pc held. The cycle counter starts at 0 on entry.
  - First cycle with res_valid=1: capture res_data, go to CHECK.
  - If the counter reaches TIMEOUT-1 with no res_valid: set timeout_mask[test_idx], fail_cnt+1, go to NEXT.
  - res_valid in the timeout cycle counts as a result; it is not a timeout.
  - res_valid outside RUN is ignored.
- CHECK:
  - core_rst=1 again.
  - Captured value == exp_data[test_idx]: set pass_mask[test_idx]. Otherwise fail_cnt+1.
  - Go to NEXT.
- NEXT:
  - core_rst=1.
  - Next enabled slot above test_idx exists: test_idx = that slot, go to RESET.
  - Otherwise stay on the last slot and go to DONE.
- DONE:
  - done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
  - Result outputs hold until the next accepted start.
- start while busy is ignored.
- test_en, entry_pc and exp_data are sampled live. The bench holds them stable while busy.
- rst asserted in any state: all registers take their reset values on that edge; no done pulse.
- fail_cnt never wraps; its maximum value is NUM_TESTS.
- Timing per test, with the first RUN cycle numbered 0 and res_valid arriving at RUN cycle k:
  - Result taken: RESET_CYCLES + (k+1) + 2 cycles (CHECK, NEXT).
  - Timeout: RESET_CYCLES + TIMEOUT + 1 cycles.

Test Plan:
Common setup: NUM_TESTS=4, RESET_CYCLES=4, TIMEOUT=16, DATA_W=PC_W=32.
1. Basic pass:
   - Stimulus: test_en=4'b0001, entry_pc[0]=0x0, exp_data[0]=0x0000000A; start at cycle 0; model core returns res_valid with 0xA on RUN cycle 3.
   - Required: core_rst high cycles 1-4 with core_pc=0; pass_mask=0001; fail_cnt=0; done pulse at cycle 11 (CHECK 9, NEXT 10, DONE 11); busy low at cycle 11.
2. Mismatch plus skip:
   - Stimulus: test_en=4'b1010; slot1 expects 0x5 and gets 0x5; slot3 expects 0xFFFFFFFF and gets 0x7FFFFFFF.
   - Required: test_idx visits 1 then 3 only; core_pc shows entry_pc[1] then entry_pc[3]; pass_mask=0010; fail_cnt=1.
3. Timeout:
   - Stimulus: slot0 enabled; res_valid never asserted.
   - Required: RUN lasts exactly 16 cycles; timeout_mask=0001; pass_mask=0; fail_cnt=1; done follows.
4. Result in the timeout cycle:
   - Stimulus: res_valid with the matching value on RUN cycle 15.
   - Required: pass_mask bit set; timeout_mask=0.
5. Empty mask and start while busy:
   - Stimulus: test_en=0 then start.
   - Required: done one cycle after start; core_rst stays 1 throughout.
   - Stimulus: second start pulse mid-sequence.
   - Required: ignored; masks not cleared.
6. Reset mid-run:
   - Stimulus: rst asserted for 1 cycle during RUN of slot2.
   - Required: next cycle IDLE, core_rst=1, busy=0, all masks and fail_cnt 0, no done pulse.
